arc4_multi: RTL and testbench

Parametrised ARC4 (RC4) decryption engine, successor to the fixed 24-bit-key `arc4` core. It supports a configurable key length and an RC4-dropN keystream discard. The permutation state S is held in an internal 256x8 register file. The engine reads a length-prefixed ciphertext from an external synchronous ROM and writes a length-prefixed plaintext to an external RAM. It sits under the key-search (crack) controller, which drives `en`/`key` and polls `rdy`.

---
 rtl/arc4_multi_if.sv | 25 ++
 rtl/arc4_multi.sv | 221 ++++++++++++++++++++++
 tb/tb_arc4_multi.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_multi_if.sv
// Bus bundle for arc4_multi: crack-controller handshake, ciphertext ROM port, plaintext RAM port.
interface arc4_multi_if #(
    parameter int unsigned KEY_BYTES = 3
);
    logic                   en;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key;
    logic [7:0]             ct_addr;
    logic [7:0]             ct_rddata;
    logic [7:0]             pt_addr;
    logic [7:0]             pt_wrdata;
    logic                   pt_wren;
    logic                   pt_ok;

    // master: controller plus memories; slave: the decryption engine
    modport master (
        output en, key, ct_rddata,
        input  rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, pt_ok
    );

    modport slave (
        input  en, key, ct_rddata,
        output rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, pt_ok
    );
endinterface

// File: rtl/arc4_multi.sv
// ARC4 decryption engine with configurable key length and dropN keystream discard.
// Optional printable-plaintext flag enabled by defining ARC4_MULTI_PTCHECK_EN.
module arc4_multi #(
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned DROP      = 0
) (
    input logic         clk,
    input logic         rst,
    arc4_multi_if.slave bus
);
    localparam int unsigned KEY_W  = 8 * KEY_BYTES;
    localparam int unsigned KIDX_W = 6;
    localparam int unsigned DCNT_W = 11;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
    localparam logic [DCNT_W-1:0] DROP_LAST = DCNT_W'((DROP > 0) ? DROP - 1 : 0);

    typedef enum logic [3:0] {
        IDLE, INIT, KSA_J, KSA_SWAP, LEN_RD, LEN_WR,
        DROP_IJ, DROP_SWAP, PRGA_IJ, PRGA_SWAP, PRGA_OUT
    } state_t;

    state_t              state;
    logic [7:0]          s [256];
    logic [7:0]          i;
    logic [7:0]          j;
    logic [7:0]          len;
    logic [8:0]          k;
    logic [DCNT_W-1:0]   dcnt;
    logic [KIDX_W-1:0]   kidx;
    logic [KEY_W-1:0]    key_lat;
    logic [KEY_W-1:0]    key_sh;
    logic                rdy_q;
    logic                pt_wren_q;
    logic [7:0]          ct_addr_q;
    logic [7:0]          pt_addr_q;
    logic [7:0]          pt_wrdata_q;

    logic [7:0] i_inc;
    logic [7:0] si;
    logic [7:0] sj;
    logic [7:0] si_inc;
    logic [7:0] t;
    logic [7:0] ks;
    logic [7:0] pt_byte;
    logic [7:0] key_byte;
    logic [8:0] k_inc;

    assign i_inc    = i + 8'd1;
    assign si       = s[i];
    assign sj       = s[j];
    assign si_inc   = s[i_inc];
    assign t        = si + sj;
    // Keystream is taken from the post-swap table: forward the swapped pair when t hits i or j.
    assign ks       = (t == i) ? sj : ((t == j) ? si : s[t]);
    assign pt_byte  = ks ^ bus.ct_rddata;
    assign key_byte = key_sh[KEY_W-1 -: 8];
    assign k_inc    = k + 9'd1;

    assign bus.rdy       = rdy_q;
    assign bus.pt_wren   = pt_wren_q;
    assign bus.ct_addr   = ct_addr_q;
    assign bus.pt_addr   = pt_addr_q;
    assign bus.pt_wrdata = pt_wrdata_q;

    // ROM address is launched on entry to LEN_RD/PRGA_IJ so its data is back one state later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rdy_q       <= 1'b1;
            pt_wren_q   <= 1'b0;
            ct_addr_q   <= 8'd0;
            pt_addr_q   <= 8'd0;
            pt_wrdata_q <= 8'd0;
            i           <= 8'd0;
            j           <= 8'd0;
            len         <= 8'd0;
            k           <= 9'd0;
            dcnt        <= '0;
            kidx        <= '0;
            key_lat     <= '0;
            key_sh      <= '0;
        end else begin
            pt_wren_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        key_lat <= bus.key;
                        key_sh  <= bus.key;
                        kidx    <= '0;
                        i       <= 8'd0;
                        j       <= 8'd0;
                        k       <= 9'd0;
                        dcnt    <= '0;
                        rdy_q   <= 1'b0;
                        state   <= INIT;
                    end
                end
                INIT: begin
                    s[i] <= i;
                    i    <= i_inc;
                    if (i == 8'hFF) begin
                        state <= KSA_J;
                    end
                end
                KSA_J: begin
                    j     <= j + si + key_byte;
                    state <= KSA_SWAP;
                end
                KSA_SWAP: begin
                    s[i] <= sj;
                    s[j] <= si;
                    i    <= i_inc;
                    // key bytes are consumed MSB-first, wrapping every KEY_BYTES steps
                    if (kidx == KIDX_LAST) begin
                        kidx   <= '0;
                        key_sh <= key_lat;
                    end else begin
                        kidx   <= kidx + KIDX_W'(1);
                        key_sh <= key_sh << 8;
                    end
                    if (i == 8'hFF) begin
                        ct_addr_q <= 8'd0;
                        state     <= LEN_RD;
                    end else begin
                        state <= KSA_J;
                    end
                end
                LEN_RD: begin
                    state <= LEN_WR;
                end
                LEN_WR: begin
                    len         <= bus.ct_rddata;
                    pt_wren_q   <= 1'b1;
                    pt_addr_q   <= 8'd0;
                    pt_wrdata_q <= bus.ct_rddata;
                    i           <= 8'd0;
                    j           <= 8'd0;
                    if (DROP != 0) begin
                        state <= DROP_IJ;
                    end else if (bus.ct_rddata == 8'd0) begin
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        k         <= 9'd1;
                        ct_addr_q <= 8'd1;
                        state     <= PRGA_IJ;
                    end
                end
                DROP_IJ: begin
                    i     <= i_inc;
                    j     <= j + si_inc;
                    state <= DROP_SWAP;
                end
                DROP_SWAP: begin
                    s[i] <= sj;
                    s[j] <= si;
                    dcnt <= dcnt + DCNT_W'(1);
                    if (dcnt != DROP_LAST) begin
                        state <= DROP_IJ;
                    end else if (len == 8'd0) begin
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        k         <= 9'd1;
                        ct_addr_q <= 8'd1;
                        state     <= PRGA_IJ;
                    end
                end
                PRGA_IJ: begin
                    i     <= i_inc;
                    j     <= j + si_inc;
                    state <= PRGA_SWAP;
                end
                PRGA_SWAP: begin
                    s[i]        <= sj;
                    s[j]        <= si;
                    pt_wren_q   <= 1'b1;
                    pt_addr_q   <= k[7:0];
                    pt_wrdata_q <= pt_byte;
                    state       <= PRGA_OUT;
                end
                PRGA_OUT: begin
                    if (k == {1'b0, len}) begin
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        k         <= k_inc;
                        ct_addr_q <= k_inc[7:0];
                        state     <= PRGA_IJ;
                    end
                end
                default: begin
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARC4_MULTI_PTCHECK_EN
    logic pt_ok_q;
    logic in_range_c;

    assign in_range_c = (pt_byte >= 8'h20) && (pt_byte <= 8'h7E);
    assign bus.pt_ok  = pt_ok_q;

    // Printable-text flag: restarted at the length write, accumulated over every payload byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            pt_ok_q <= 1'b1;
        end else if (state == LEN_WR) begin
            pt_ok_q <= 1'b1;
        end else if (state == PRGA_SWAP) begin
            pt_ok_q <= pt_ok_q & in_range_c;
        end
    end
`else
    assign bus.pt_ok = 1'b1;
`endif

endmodule

// File: tb/tb_arc4_multi.sv
// Directed bench for arc4_multi: four engines (key lengths 3/4/6, DROP 0/1) with ROM models.
module tb_arc4_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic        en          [4];
    logic [47:0] keyv        [4];
    logic        rdy         [4];
    logic        pt_wren_w   [4];
    logic        pt_ok_w     [4];
    logic [7:0]  ct_addr_w   [4];
    logic [7:0]  pt_addr_w   [4];
    logic [7:0]  pt_wrdata_w [4];
    logic [7:0]  ct_rd       [4];
    logic [7:0]  rom         [4][256];

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  obs [256];
    int          obs_n;
    int          low_cyc;
    int          addr_bad;
    logic        ok_end;
    logic [7:0]  v1_ct [$];
    string       v1_pt;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int unsigned KB = (gi == 1) ? 4 : ((gi == 2) ? 6 : 3);
        localparam int unsigned DR = (gi == 3) ? 1 : 0;
        arc4_multi_if #(.KEY_BYTES(KB)) bus ();
        assign bus.en          = en[gi];
        assign bus.key         = keyv[gi][8*KB-1:0];
        assign bus.ct_rddata   = ct_rd[gi];
        assign rdy[gi]         = bus.rdy;
        assign pt_wren_w[gi]   = bus.pt_wren;
        assign pt_ok_w[gi]     = bus.pt_ok;
        assign ct_addr_w[gi]   = bus.ct_addr;
        assign pt_addr_w[gi]   = bus.pt_addr;
        assign pt_wrdata_w[gi] = bus.pt_wrdata;
        arc4_multi #(.KEY_BYTES(KB), .DROP(DR)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // synchronous ROMs, one cycle latency
    always @(posedge clk) begin
        for (int g = 0; g < 4; g++) ct_rd[g] <= rom[g][ct_addr_w[g]];
    end

    task automatic load_ct(input int g, input logic [7:0] c[$]);
        for (int n = 0; n < c.size(); n++) rom[g][n] = c[n];
    endtask

    task automatic sample_wr(input int g);
        if (pt_wren_w[g] === 1'b1) begin
            if (pt_addr_w[g] !== 8'(obs_n)) addr_bad++;
            obs[pt_addr_w[g]] = pt_wrdata_w[g];
            obs_n++;
        end
    endtask

    // start engine g, watch it until rdy returns; optional en/rst pulses at a busy-cycle index
    task automatic run_msg(input int g, input logic [47:0] k, input int en_at, input int rst_at);
        int guard;
        for (int n = 0; n < 256; n++) obs[n] = 'x;
        obs_n = 0; addr_bad = 0; low_cyc = 0; guard = 0;
        keyv[g] = k;
        en[g] = 1'b1;
        @(negedge clk);
        en[g] = 1'b0;
        while (rdy[g] === 1'b0 && guard < 5000) begin
            sample_wr(g);
            low_cyc++;
            en[g] = (guard == en_at);
            rst   = (guard == rst_at);
            @(negedge clk);
            guard++;
        end
        rst = 1'b0;
        en[g] = 1'b0;
        ok_end = pt_ok_w[g];
        repeat (3) begin
            sample_wr(g);
            @(negedge clk);
        end
    endtask

    function automatic logic model_ptok(input logic [23:0] k, input logic [7:0] c[$]);
        logic [7:0] sm [256];
        logic [7:0] a, b, tmp, p;
        logic       ok;
        ok = 1'b1;
        for (int n = 0; n < 256; n++) sm[n] = 8'(n);
        b = 8'd0;
        for (int n = 0; n < 256; n++) begin
            b = b + sm[n] + k[23-8*(n%3) -: 8];
            tmp = sm[n]; sm[n] = sm[b]; sm[b] = tmp;
        end
        a = 8'd0; b = 8'd0;
        for (int n = 1; n <= int'(c[0]); n++) begin
            a = a + 8'd1;
            b = b + sm[a];
            tmp = sm[a]; sm[a] = sm[b]; sm[b] = tmp;
            p = sm[8'(sm[a] + sm[b])] ^ c[n];
            if (p < 8'h20 || p > 8'h7E) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            total++; if (rdy[g] !== 1'b1) begin bad++; $display("FAIL reset_rdy[%0d]: got %b want 1", g, rdy[g]); end
            total++; if (pt_wren_w[g] !== 1'b0) begin bad++; $display("FAIL reset_wren[%0d]: got %b want 0", g, pt_wren_w[g]); end
        end
        total++; if (pt_ok_w[0] !== 1'b1) begin bad++; $display("FAIL reset_pt_ok: got %b want 1", pt_ok_w[0]); end
        total++; if (ct_addr_w[0] !== 8'h00) begin bad++; $display("FAIL reset_ct_addr: got %h want 00", ct_addr_w[0]); end
        total++; if (pt_addr_w[0] !== 8'h00) begin bad++; $display("FAIL reset_pt_addr: got %h want 00", pt_addr_w[0]); end
        total++; if (pt_wrdata_w[0] !== 8'h00) begin bad++; $display("FAIL reset_pt_wrdata: got %h want 00", pt_wrdata_w[0]); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        for (int v = 0; v < 3; v++) begin
            int          g;
            logic [47:0] k;
            logic [7:0]  c [$];
            string       m;
            case (v)
                0: begin g = 0; k = 48'h4B6579; c = v1_ct; m = v1_pt; end
                1: begin g = 1; k = 48'h57696B69;
                         c = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20}; m = "pedia"; end
                default: begin g = 2; k = 48'h536563726574;
                         c = '{8'h0E, 8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B,
                               8'h38, 8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
                         m = "Attack at dawn"; end
            endcase
            load_ct(g, c);
            run_msg(g, k, -1, -1);
            total++; if (low_cyc != 770 + 3*m.len()) begin bad++; $display("FAIL vec%0d_busy: got %0d want %0d", v+1, low_cyc, 770 + 3*m.len()); end
            total++; if (obs_n != m.len() + 1) begin bad++; $display("FAIL vec%0d_writes: got %0d want %0d", v+1, obs_n, m.len() + 1); end
            total++; if (addr_bad != 0) begin bad++; $display("FAIL vec%0d_order: got %0d want 0", v+1, addr_bad); end
            total++; if (obs[0] !== 8'(m.len())) begin bad++; $display("FAIL vec%0d_len: got %h want %h", v+1, obs[0], 8'(m.len())); end
            for (int x = 0; x < m.len(); x++) begin
                total++; if (obs[x+1] !== 8'(m[x])) begin bad++; $display("FAIL vec%0d_pt[%0d]: got %h want %h", v+1, x+1, obs[x+1], 8'(m[x])); end
            end
            total++; if (ok_end !== 1'b1) begin bad++; $display("FAIL vec%0d_pt_ok: got %b want 1", v+1, ok_end); end
        end
    endtask

    task automatic test_drop();
        load_ct(3, '{8'h01, 8'hBB});
        run_msg(3, 48'h4B6579, -1, -1);
        total++; if (low_cyc != 775) begin bad++; $display("FAIL drop_busy: got %0d want 775", low_cyc); end
        total++; if (obs_n != 2) begin bad++; $display("FAIL drop_writes: got %0d want 2", obs_n); end
        total++; if (obs[0] !== 8'h01) begin bad++; $display("FAIL drop_len: got %h want 01", obs[0]); end
        total++; if (obs[1] !== 8'h24) begin bad++; $display("FAIL drop_pt1: got %h want 24", obs[1]); end
    endtask

    task automatic test_len0();
        load_ct(0, '{8'h00});
        run_msg(0, 48'h4B6579, -1, -1);
        total++; if (low_cyc != 770) begin bad++; $display("FAIL len0_busy: got %0d want 770", low_cyc); end
        total++; if (obs_n != 1) begin bad++; $display("FAIL len0_writes: got %0d want 1", obs_n); end
        total++; if (obs[0] !== 8'h00) begin bad++; $display("FAIL len0_pt0: got %h want 00", obs[0]); end
    endtask

    task automatic test_ptcheck();
        logic exp_ok;
`ifdef ARC4_MULTI_PTCHECK_EN
        exp_ok = model_ptok(24'h4B6578, v1_ct);
`else
        exp_ok = 1'b1;
`endif
        load_ct(0, v1_ct);
        run_msg(0, 48'h4B6578, -1, -1);
        total++; if (ok_end !== exp_ok) begin bad++; $display("FAIL wrongkey_pt_ok: got %b want %b", ok_end, exp_ok); end
        total++; if (obs_n != 10) begin bad++; $display("FAIL wrongkey_writes: got %0d want 10", obs_n); end
    endtask

    task automatic test_reset_mid();
        load_ct(0, v1_ct);
        run_msg(0, 48'h4B6579, -1, 400);
        total++; if (low_cyc != 401) begin bad++; $display("FAIL rstmid_busy: got %0d want 401", low_cyc); end
        total++; if (obs_n != 0) begin bad++; $display("FAIL rstmid_writes: got %0d want 0", obs_n); end
        total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL rstmid_rdy: got %b want 1", rdy[0]); end
        run_msg(0, 48'h4B6579, -1, -1);
        total++; if (low_cyc != 797) begin bad++; $display("FAIL restart_busy: got %0d want 797", low_cyc); end
        total++; if (obs_n != 10) begin bad++; $display("FAIL restart_writes: got %0d want 10", obs_n); end
        for (int x = 0; x < 9; x++) begin
            total++; if (obs[x+1] !== 8'(v1_pt[x])) begin bad++; $display("FAIL restart_pt[%0d]: got %h want %h", x+1, obs[x+1], 8'(v1_pt[x])); end
        end
    endtask

    task automatic test_en_busy();
        load_ct(0, v1_ct);
        run_msg(0, 48'h4B6579, 780, -1);
        total++; if (low_cyc != 797) begin bad++; $display("FAIL enbusy_busy: got %0d want 797", low_cyc); end
        total++; if (obs_n != 10) begin bad++; $display("FAIL enbusy_writes: got %0d want 10", obs_n); end
        total++; if (addr_bad != 0) begin bad++; $display("FAIL enbusy_order: got %0d want 0", addr_bad); end
        total++; if (obs[9] !== 8'h74) begin bad++; $display("FAIL enbusy_pt9: got %h want 74", obs[9]); end
        total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL enbusy_idle: got %b want 1", rdy[0]); end
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 4; g++) begin en[g] = 1'b0; keyv[g] = '0; end
        v1_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        v1_pt = "Plaintext";
        @(negedge clk);
        test_reset();
        test_vectors();
        test_drop();
        test_len0();
        test_ptcheck();
        test_reset_mid();
        test_en_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
